// File: rtl/sbus_pkg.sv
// SBUS framing constants, decoder state encoding and a saturating-increment helper.
package sbus_pkg;

  localparam logic [7:0] SBUS_HEADER        = 8'h0F;
  localparam logic [7:0] SBUS_FOOTER        = 8'h00;
  localparam int         SBUS_PAYLOAD_BYTES = 22;
  localparam int         SBUS_CHANNELS      = 16;
  localparam int         SBUS_CH_BITS       = 11;
  localparam int         SBUS_PAYLOAD_BITS  = SBUS_PAYLOAD_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    FLAGS,
    FOOTER
  } sbus_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sbus_timeout.sv
// Clearable, enabled cycle counter with a sticky expiry flag. expired_o is high in the
// LIMIT-th consecutive enabled cycle (that cycle included) and stays high until cleared.
module sbus_timeout #(
  parameter int LIMIT = 4800
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int             W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/sbus_decoder.sv
// SBUS frame decoder: assembles a 25-byte frame in shadow registers and publishes channels
// and flags atomically on a good footer. Stale-link watchdog enabled by SBUS_STALE_EN.
module sbus_decoder
  import sbus_pkg::*;
#(
  parameter int GAP_CLKS = 4800
`ifdef SBUS_STALE_EN
  , parameter int STALE_CLKS = 1600000
`endif
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  rxDataReady,
  input  logic [7:0]                            rxData,
  output logic [SBUS_CHANNELS*SBUS_CH_BITS-1:0] channels,
  output logic                                  ch17,
  output logic                                  ch18,
  output logic                                  frameLost,
  output logic                                  failsafe,
  output logic                                  frameValid,
  output logic [7:0]                            errorCount,
  output logic                                  stale
);

  localparam logic [4:0] LAST_IDX = 5'(SBUS_PAYLOAD_BYTES - 1);

  sbus_state_t                  state_q, state_d;
  logic [4:0]                   idx_q, idx_d;
  logic [SBUS_PAYLOAD_BITS-1:0] shadow_q;
  logic [3:0]                   sflags_q;
  logic [SBUS_PAYLOAD_BITS-1:0] channels_q;
  logic [3:0]                   flags_q;
  logic                         valid_q;
  logic [7:0]                   err_q;
  logic                         load_byte, load_flags, commit, err_inc;
  logic                         gap_expired;

  sbus_timeout #(.LIMIT(GAP_CLKS)) u_gap (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (rxDataReady || (state_q == IDLE)),
    .enable_i (state_q != IDLE),
    .expired_o(gap_expired)
  );

  // An arriving byte always takes priority over a gap expiry in the same cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_byte  = 1'b0;
    load_flags = 1'b0;
    commit     = 1'b0;
    err_inc    = 1'b0;
    if (rxDataReady) begin
      case (state_q)
        IDLE: begin
          if (rxData == SBUS_HEADER) begin
            state_d = PAYLOAD;
            idx_d   = '0;
          end
        end
        PAYLOAD: begin
          load_byte = 1'b1;
          if (idx_q == LAST_IDX) state_d = FLAGS;
          else                   idx_d   = idx_q + 5'd1;
        end
        FLAGS: begin
          load_flags = 1'b1;
          state_d    = FOOTER;
        end
        FOOTER: begin
          if (rxData == SBUS_FOOTER) commit  = 1'b1;
          else                       err_inc = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (gap_expired && (state_q != IDLE)) begin
      state_d = IDLE;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      sflags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_byte)  shadow_q[{idx_q, 3'b000} +: 8] <= rxData;
      if (load_flags) sflags_q <= rxData[3:0];
    end
  end

  // flags_q[3] resets high so failsafe reads 1 until a real frame says otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      channels_q <= '0;
      flags_q    <= 4'b1000;
      valid_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      valid_q <= commit;
      if (commit) begin
        channels_q <= shadow_q;
        flags_q    <= sflags_q;
      end
      if (err_inc) err_q <= sat_inc8(err_q);
    end
  end

`ifdef SBUS_STALE_EN
  logic wd_expired;
  logic stale_q, stale_d;
  logic failsafe_q;

  sbus_timeout #(.LIMIT(STALE_CLKS)) u_stale (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (commit),
    .enable_i (1'b1),
    .expired_o(wd_expired)
  );

  always_comb begin
    stale_d = stale_q;
    if (commit)          stale_d = 1'b0;
    else if (wd_expired) stale_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stale_q    <= 1'b1;
      failsafe_q <= 1'b1;
    end else begin
      stale_q    <= stale_d;
      failsafe_q <= stale_d | (commit ? sflags_q[3] : flags_q[3]);
    end
  end

  assign stale    = stale_q;
  assign failsafe = failsafe_q;
`else
  assign stale    = 1'b0;
  assign failsafe = flags_q[3];
`endif

  assign channels   = channels_q;
  assign ch17       = flags_q[0];
  assign ch18       = flags_q[1];
  assign frameLost  = flags_q[2];
  assign frameValid = valid_q;
  assign errorCount = err_q;

endmodule
